// File: rtl/tick_period_monitor.sv
// Tick interval monitor: measures strobe spacing, locks, flags misses.
// Optional TICK_EDGE_EN: treat tick_in as a level and count rising edges.
module tick_period_monitor #(
  parameter int unsigned EXPECT_PERIOD = 1000,
  parameter int unsigned TOLERANCE     = 0,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             origin_clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [7:0]       miss_cnt
);

  localparam int unsigned HI_I = EXPECT_PERIOD + TOLERANCE;
  localparam int unsigned LO_I =
    (EXPECT_PERIOD > TOLERANCE + 1) ? EXPECT_PERIOD - TOLERANCE : 1;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(HI_I);
  localparam logic [CNT_W-1:0] LOW   = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [7:0]       LOCK_N = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE, ACQUIRE, LOCKED, FAULT
  } state_t;

  state_t           state, state_n;
  logic             tick;
  logic [CNT_W-1:0] icnt;
  logic             armed;
  logic [7:0]       good_cnt;
  logic             measure, in_range, miss;
  logic             good_ev, bad_ev, clr, lock_hit;
  logic             locked_n, fault_n;

`ifdef TICK_EDGE_EN
  logic tick_q, edge_q;

  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
      edge_q <= tick_in & ~tick_q;
    end
  end

  assign tick = edge_q;
`else
  assign tick = tick_in;
`endif

  assign measure  = tick & armed;
  assign in_range = (icnt >= LOW) && (icnt <= LIMIT);
  // icnt keeps counting past LIMIT, so this fires once per gap
  assign miss     = armed & ~tick & (icnt == LIMIT);
  assign good_ev  = measure & in_range;
  assign bad_ev   = (measure & ~in_range) | miss;
  assign clr      = clear & (state != IDLE);
  assign lock_hit = good_ev && ((good_cnt + 8'd1) == LOCK_N);

  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt         <= '0;
      armed        <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      miss_cnt     <= '0;
      good_cnt     <= '0;
    end else begin
      if (tick)
        icnt <= ONE;
      else if (icnt != '1)
        icnt <= icnt + ONE;
      if (tick)
        armed <= 1'b1;
      period_valid <= measure;
      if (measure)
        period <= icnt;
      if (clr)
        miss_cnt <= '0;
      else if (miss && miss_cnt != 8'hff)
        miss_cnt <= miss_cnt + 8'd1;
      if (clr || state != ACQUIRE || bad_ev)
        good_cnt <= '0;
      else if (good_ev)
        good_cnt <= good_cnt + 8'd1;
    end
  end

  always_ff @(posedge origin_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      locked <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_n;
      locked <= locked_n;
      fault  <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (tick) state_n = ACQUIRE;
      ACQUIRE: if (lock_hit) state_n = LOCKED;
      LOCKED:  if (bad_ev) state_n = FAULT;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
    if (clr)
      state_n = ACQUIRE;
  end

  always_comb begin
    locked_n = (state_n == LOCKED);
    fault_n  = (state_n == FAULT);
  end

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor.
// EXPECT_PERIOD=10, TOLERANCE=1, LOCK_COUNT=3.
module tb_tick_period_monitor;

  logic        clk;
  logic        rst_n;
  logic        tick_in;
  logic        clear;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        fault;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;

  tick_period_monitor #(
    .EXPECT_PERIOD(10),
    .TOLERANCE(1),
    .LOCK_COUNT(3),
    .CNT_W(32)
  ) dut (
    .origin_clk(clk),
    .rst_n(rst_n),
    .tick_in(tick_in),
    .clear(clear),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .fault(fault),
    .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // next tick edge lands gap cycles after the previous one
  task automatic tick_after(input int gap);
    tick_in = 1'b0;
    repeat (gap - 1) cyc();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    tick_in = 1'b0;
    clear   = 1'b0;
    repeat (3) cyc();
    check("rst_period", period, 0);
    check("rst_valid", 32'(period_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_miss", 32'(miss_cnt), 0);
    rst_n = 1'b1;
    cyc();

    // acquire and lock at period 10
    tick_after(3);
    check("arm_no_valid", 32'(period_valid), 0);
    tick_after(10);
    check("t2_valid", 32'(period_valid), 1);
    check("t2_period", period, 10);
    check("t2_locked", 32'(locked), 0);
    cyc();
    check("valid_pulse", 32'(period_valid), 0);
    tick_after(9);
    check("t3_locked", 32'(locked), 0);
    tick_after(10);
    check("t4_locked", 32'(locked), 1);
    check("t4_fault", 32'(fault), 0);
    check("t4_miss", 32'(miss_cnt), 0);

    // early tick while locked
    tick_after(8);
    check("early_period", period, 8);
    check("early_fault", 32'(fault), 1);
    check("early_locked", 32'(locked), 0);
    check("early_miss", 32'(miss_cnt), 0);

    // clear then relock at 9-cycle spacing
    pulse_clear();
    check("clr_fault", 32'(fault), 0);
    check("clr_locked", 32'(locked), 0);
    check("clr_miss", 32'(miss_cnt), 0);
    tick_after(9);
    check("re1_period", period, 10);
    tick_after(9);
    check("re2_period", period, 9);
    check("re2_locked", 32'(locked), 0);
    tick_after(9);
    check("re3_locked", 32'(locked), 1);

    // 12-cycle gap while locked
    repeat (10) cyc();
    check("gap_pre_fault", 32'(fault), 0);
    cyc();
    check("gap_fault", 32'(fault), 1);
    check("gap_locked", 32'(locked), 0);
    check("gap_miss", 32'(miss_cnt), 1);
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
    check("gap_period", period, 12);
    check("gap_valid", 32'(period_valid), 1);

    // acquire pattern 10,10,15,10,10,10
    pulse_clear();
    check("clr2_miss", 32'(miss_cnt), 0);
    tick_after(9);
    tick_after(10);
    check("seq2_locked", 32'(locked), 0);
    tick_after(15);
    check("seq3_period", period, 15);
    check("seq3_miss", 32'(miss_cnt), 1);
    check("seq3_fault", 32'(fault), 0);
    tick_after(10);
    tick_after(10);
    check("seq5_locked", 32'(locked), 0);
    tick_after(10);
    check("seq6_locked", 32'(locked), 1);

    // async reset mid-interval
    repeat (4) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_miss", 32'(miss_cnt), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    tick_after(5);
    check("rearm_no_valid", 32'(period_valid), 0);
    tick_after(1);
    check("b2b_period", period, 1);
    check("b2b_valid", 32'(period_valid), 1);
    tick_after(10);
    check("rearm_period", period, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
